// File: rtl/shift_pkg.sv
// Shared types for the shift controller: FSM state and datapath mode.
package shift_pkg;

  // Encoding is visible on state_o, so values are fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PAR  = 2'd1,
    SER  = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } mode_e;

endpackage

// File: rtl/shift_ctrl_if.sv
// Handshake and data bundle between a requester and shift_ctrl.
interface shift_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             req_par;
  logic             req_ser;
  logic [WIDTH-1:0] din;
  logic             hold;
  logic             ack;
  logic             busy;
  logic             done;
  logic             ser_bit;
  logic [WIDTH-1:0] q;
  logic [1:0]       state_o;

  modport master (
    output req_par, req_ser, din, hold,
    input  ack, busy, done, ser_bit, q, state_o
  );

  modport slave (
    input  req_par, req_ser, din, hold,
    output ack, busy, done, ser_bit, q, state_o
  );
endinterface

// File: rtl/shift_reg.sv
// Shift register datapath: hold, parallel load, or shift right with serial input at the MSB.
module shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_2,
  input  logic             reset,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next-state select by mode.
  always_comb begin
    q_d = q_q;
    unique case (mode)
      LOAD:    q_d = par_in;
      SHIFT:   q_d = {ser_in, q_q[WIDTH-1:1]};
      default: q_d = q_q;
    endcase
  end

  // Register with asynchronous clear.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/shift_ctrl.sv
// Arbitrating load controller: accepts parallel or serial load requests and
// drives the shift_reg datapath, with ack/done pulses and a busy level.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SER_FIRST = 1'b0
) (
  input  logic clk_2,
  input  logic reset,
  shift_ctrl_if.slave bus
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] cap_q;
  logic [CW-1:0]    cnt_q;
  logic             ack_q;
  logic             done_q;

  mode_e            mode;
  logic             ser_in;
  logic             take_par;

  // Tie-break between simultaneous requests.
  assign take_par = bus.req_par && (!bus.req_ser || !SER_FIRST);

  // Datapath control decoded from registered state; hold only matters in SER.
  always_comb begin
    mode   = HOLD;
    ser_in = 1'b0;
    unique case (state_q)
      PAR: mode = LOAD;
      SER: begin
        ser_in = cap_q[cnt_q];
        if (!bus.hold) mode = SHIFT;
      end
      default: mode = HOLD;
    endcase
  end

  // Control FSM with registered ack/done pulses.
  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cap_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (take_par) begin
            state_q <= PAR;
            cap_q   <= bus.din;
            ack_q   <= 1'b1;
          end else if (bus.req_ser) begin
            state_q <= SER;
            cap_q   <= bus.din;
            cnt_q   <= '0;
            ack_q   <= 1'b1;
          end
        end
        PAR: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        SER: begin
          if (!bus.hold) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= DONE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  shift_reg #(
    .WIDTH(WIDTH)
  ) u_shift_reg (
    .clk_2 (clk_2),
    .reset (reset),
    .mode  (mode),
    .par_in(cap_q),
    .ser_in(ser_in),
    .q     (bus.q)
  );

  assign bus.ack     = ack_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q == PAR) || (state_q == SER);
  assign bus.ser_bit = ser_in;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Scoreboard bench for shift_ctrl: two instances cover both tie-break settings.
module tb_shift_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0] sb0[$];
  logic [3:0] sb1[$];

  always #5 clk = ~clk;

  shift_ctrl_if #(.WIDTH(4)) bus0 ();
  shift_ctrl_if #(.WIDTH(4)) bus1 ();

  shift_ctrl #(.WIDTH(4), .SER_FIRST(1'b0)) dut0 (
    .clk_2(clk), .reset(reset), .bus(bus0)
  );
  shift_ctrl #(.WIDTH(4), .SER_FIRST(1'b1)) dut1 (
    .clk_2(clk), .reset(reset), .bus(bus1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (bus0.state_o !== 2'd0 || bus0.q !== 4'h0 || bus0.ack !== 1'b0 ||
        bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.ser_bit !== 1'b0) begin
      n_err++;
      $display("FAIL reset0: state=%0d q=%h ack=%b done=%b busy=%b ser=%b, required all 0",
               bus0.state_o, bus0.q, bus0.ack, bus0.done, bus0.busy, bus0.ser_bit);
    end
    n_cmp++;
    if (bus1.state_o !== 2'd0 || bus1.q !== 4'h0 || bus1.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset1: state=%0d q=%h busy=%b, required all 0",
               bus1.state_o, bus1.q, bus1.busy);
    end
    step();
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (bus0.state_o !== 2'd0 || bus0.ack !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: state=%0d ack=%b, required 0 0", bus0.state_o, bus0.ack);
    end
  endtask

  task automatic test_par(input logic [3:0] d);
    logic [3:0] e;
    sb0.push_back(d);
    bus0.din = d;
    bus0.req_par = 1'b1;
    step();
    n_cmp++;
    if (bus0.ack !== 1'b1 || bus0.state_o !== 2'd1 || bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
      n_err++;
      $display("FAIL par_ack: ack=%b state=%0d busy=%b done=%b, required 1 1 1 0",
               bus0.ack, bus0.state_o, bus0.busy, bus0.done);
    end
    bus0.req_par = 1'b0;
    bus0.din = ~d;
    bus0.hold = 1'b1;
    step();
    bus0.hold = 1'b0;
    e = sb0.pop_front();
    n_cmp++;
    if (bus0.done !== 1'b1 || bus0.q !== e || bus0.busy !== 1'b0 || bus0.ack !== 1'b0 ||
        bus0.state_o !== 2'd3) begin
      n_err++;
      $display("FAIL par_done: done=%b q=%h busy=%b ack=%b state=%0d, required 1 %h 0 0 3",
               bus0.done, bus0.q, bus0.busy, bus0.ack, bus0.state_o, e);
    end
    step();
    n_cmp++;
    if (bus0.done !== 1'b0 || bus0.state_o !== 2'd0 || bus0.q !== e) begin
      n_err++;
      $display("FAIL par_idle: done=%b state=%0d q=%h, required 0 0 %h",
               bus0.done, bus0.state_o, bus0.q, e);
    end
  endtask

  task automatic test_ser(input logic [3:0] d, input int hold_at, input int hold_len, input string nm);
    logic [3:0] mq;
    logic [3:0] e;
    int shifts, held, cyc;
    mq = bus0.q;
    sb0.push_back(d);
    bus0.din = d;
    bus0.req_ser = 1'b1;
    step();
    n_cmp++;
    if (bus0.ack !== 1'b1 || bus0.state_o !== 2'd2) begin
      n_err++;
      $display("FAIL %s_ack: ack=%b state=%0d, required 1 2", nm, bus0.ack, bus0.state_o);
    end
    bus0.req_ser = 1'b0;
    bus0.din = ~d;
    shifts = 0;
    held = 0;
    cyc = 0;
    while (bus0.state_o === 2'd2 && cyc < 40) begin
      n_cmp++;
      if (bus0.ser_bit !== d[shifts] || bus0.q !== mq || bus0.busy !== 1'b1) begin
        n_err++;
        $display("FAIL %s_shift%0d: ser_bit=%b q=%h busy=%b, required %b %h 1",
                 nm, cyc, bus0.ser_bit, bus0.q, bus0.busy, d[shifts], mq);
      end
      if (shifts == hold_at && held < hold_len) begin
        bus0.hold = 1'b1;
        held++;
      end else begin
        bus0.hold = 1'b0;
        mq = {d[shifts], mq[3:1]};
        shifts++;
      end
      cyc++;
      step();
    end
    bus0.hold = 1'b0;
    n_cmp++;
    if (cyc !== 4 + hold_len) begin
      n_err++;
      $display("FAIL %s_busy_cycles: got %0d, required %0d", nm, cyc, 4 + hold_len);
    end
    e = sb0.pop_front();
    n_cmp++;
    if (bus0.done !== 1'b1 || bus0.state_o !== 2'd3 || bus0.q !== e || bus0.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done: done=%b state=%0d q=%h busy=%b, required 1 3 %h 0",
               nm, bus0.done, bus0.state_o, bus0.q, bus0.busy, e);
    end
    step();
    n_cmp++;
    if (bus0.done !== 1'b0 || bus0.state_o !== 2'd0 || bus0.q !== e) begin
      n_err++;
      $display("FAIL %s_idle: done=%b state=%0d q=%h, required 0 0 %h",
               nm, bus0.done, bus0.state_o, bus0.q, e);
    end
  endtask

  task automatic test_tie();
    logic [3:0] e;
    int cyc;
    sb0.push_back(4'h5);
    sb1.push_back(4'h5);
    bus0.din = 4'h5; bus0.req_par = 1'b1; bus0.req_ser = 1'b1;
    bus1.din = 4'h5; bus1.req_par = 1'b1; bus1.req_ser = 1'b1;
    step();
    n_cmp++;
    if (bus0.state_o !== 2'd1 || bus1.state_o !== 2'd2 || bus0.ack !== 1'b1 || bus1.ack !== 1'b1) begin
      n_err++;
      $display("FAIL tie_pick: states %0d/%0d acks %b/%b, required 1/2 1/1",
               bus0.state_o, bus1.state_o, bus0.ack, bus1.ack);
    end
    bus0.req_par = 1'b0; bus0.req_ser = 1'b0;
    bus1.req_par = 1'b0; bus1.req_ser = 1'b0;
    step();
    e = sb0.pop_front();
    n_cmp++;
    if (bus0.done !== 1'b1 || bus0.q !== e) begin
      n_err++;
      $display("FAIL tie_par_done: done=%b q=%h, required 1 %h", bus0.done, bus0.q, e);
    end
    cyc = 1;
    while (bus1.done !== 1'b1 && cyc < 20) begin
      step();
      cyc++;
    end
    e = sb1.pop_front();
    n_cmp++;
    if (bus1.done !== 1'b1 || cyc !== 4 || bus1.q !== e) begin
      n_err++;
      $display("FAIL tie_ser_done: done=%b after %0d cycles q=%h, required 1 after 4 q=%h",
               bus1.done, cyc, bus1.q, e);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int dn;
    bus0.din = 4'h9;
    bus0.req_ser = 1'b1;
    step();
    bus0.req_ser = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus0.state_o !== 2'd2 || bus0.q === 4'h0) begin
      n_err++;
      $display("FAIL rst_mid_pre: state=%0d q=%h, required state 2 and nonzero q", bus0.state_o, bus0.q);
    end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (bus0.state_o !== 2'd0 || bus0.q !== 4'h0 || bus0.busy !== 1'b0 || bus0.ser_bit !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_async: state=%0d q=%h busy=%b ser=%b, required 0 0 0 0",
               bus0.state_o, bus0.q, bus0.busy, bus0.ser_bit);
    end
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus0.done === 1'b1) dn++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus0.done === 1'b1 || bus0.state_o !== 2'd0) dn++;
    end
    n_cmp++;
    if (dn !== 0) begin
      n_err++;
      $display("FAIL rst_mid_nodone: %0d bad cycles (done or non-idle), required 0", dn);
    end
    test_par(4'h3);
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    int cyc;
    sb0.push_back(4'h6);
    bus0.din = 4'h6;
    bus0.req_ser = 1'b1;
    step();
    n_cmp++;
    if (bus0.ack !== 1'b1 || bus0.state_o !== 2'd2) begin
      n_err++;
      $display("FAIL b2b_ack1: ack=%b state=%0d, required 1 2", bus0.ack, bus0.state_o);
    end
    bus0.din = 4'h3;
    bus0.req_par = 1'b1;
    cyc = 0;
    while (bus0.state_o === 2'd2 && cyc < 20) begin
      step();
      cyc++;
    end
    e = sb0.pop_front();
    n_cmp++;
    if (cyc !== 4 || bus0.state_o !== 2'd3 || bus0.done !== 1'b1 || bus0.q !== e) begin
      n_err++;
      $display("FAIL b2b_first: %0d cycles state=%0d done=%b q=%h, required 4 3 1 %h",
               cyc, bus0.state_o, bus0.done, bus0.q, e);
    end
    sb0.push_back(4'h3);
    step();
    n_cmp++;
    if (bus0.state_o !== 2'd0 || bus0.ack !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_early_ack: state=%0d ack=%b, required 0 0", bus0.state_o, bus0.ack);
    end
    step();
    n_cmp++;
    if (bus0.ack !== 1'b1 || bus0.state_o !== 2'd1) begin
      n_err++;
      $display("FAIL b2b_ack2: ack=%b state=%0d, required 1 1", bus0.ack, bus0.state_o);
    end
    bus0.req_par = 1'b0;
    bus0.req_ser = 1'b0;
    step();
    e = sb0.pop_front();
    n_cmp++;
    if (bus0.done !== 1'b1 || bus0.q !== e) begin
      n_err++;
      $display("FAIL b2b_second: done=%b q=%h, required 1 %h", bus0.done, bus0.q, e);
    end
    step();
  endtask

  initial begin
    bus0.req_par = 1'b0; bus0.req_ser = 1'b0; bus0.hold = 1'b0; bus0.din = 4'h0;
    bus1.req_par = 1'b0; bus1.req_ser = 1'b0; bus1.hold = 1'b0; bus1.din = 4'h0;
    test_reset();
    test_par(4'hA);
    test_ser(4'h6, -1, 0, "ser6");
    test_tie();
    test_ser(4'h9, 2, 3, "hold9");
    test_reset_mid();
    test_back_to_back();
    test_ser(4'hC, 0, 1, "holdC");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
